rpn_stack_engine: RTL and testbench

RPN_STACK_ENGINE -- requirements
Module: rpn_stack_engine

---
 rtl/calc_pkg.sv | 24 ++
 rtl/rpn_stack_mem.sv | 66 ++++++
 rtl/rpn_stack_engine.sv | 204 ++++++++++++++++++++
 tb/tb_rpn_stack_engine.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the RPN calculator: token codes, FSM states, default sizes.
package calc_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_DEPTH = 8;

    localparam logic [3:0] TOK_ADD   = 4'hA;
    localparam logic [3:0] TOK_SUB   = 4'hB;
    localparam logic [3:0] TOK_MUL   = 4'hC;
    localparam logic [3:0] TOK_DROP  = 4'hD;
    localparam logic [3:0] TOK_ENTER = 4'hE;
    localparam logic [3:0] TOK_CLEAR = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    function automatic logic is_digit(input logic [3:0] tok);
        return tok <= 4'd9;
    endfunction

endpackage

// File: rtl/rpn_stack_mem.sv
// LIFO storage for the RPN engine: register array plus occupancy pointer.
module rpn_stack_mem
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       replace,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           top_c,
    output logic [WIDTH-1:0]           next_c,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full_c,
    output logic                       empty_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d;
    logic             push_ok_c, pop_ok_c, we_c;
    logic [AW-1:0]    waddr_c;

    assign full_c  = (ptr_q == PW'(DEPTH));
    assign empty_c = (ptr_q == '0);
    assign top_c   = mem_q[AW'(ptr_q - PW'(1))];
    assign next_c  = mem_q[AW'(ptr_q - PW'(2))];
    assign count   = ptr_q;

    // Replace with pop overwrites the entry that becomes the new top.
    always_comb begin
        push_ok_c = push && !full_c;
        pop_ok_c  = pop && !empty_c;
        ptr_d     = ptr_q;
        if (clear) begin
            ptr_d = '0;
        end else if (push_ok_c && !pop_ok_c) begin
            ptr_d = ptr_q + PW'(1);
        end else if (pop_ok_c && !push_ok_c) begin
            ptr_d = ptr_q - PW'(1);
        end
        we_c    = !clear && (push_ok_c || replace);
        waddr_c = push_ok_c ? AW'(ptr_q) : AW'(ptr_d - PW'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we_c) begin
            mem_q[waddr_c] <= wdata;
        end
    end

endmodule

// File: rtl/rpn_stack_engine.sv
// RPN calculator core: keypad token FSM driving a LIFO operand stack.
// Define RPN_STACK_MUL_EN to build the multiplier; otherwise token C is a no-op.
module rpn_stack_engine
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0]             token,
    input  logic                   token_valid,
    output logic [WIDTH-1:0]       top,
    output logic [$clog2(DEPTH):0] depth,
    output logic                   entering,
    output logic                   busy,
    output logic                   err_overflow,
    output logic                   err_underflow
);

    localparam int unsigned PW = $clog2(DEPTH) + 1;
`ifdef RPN_STACK_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] entry_q, entry_d;
    logic [3:0]       op_q, op_d;
    logic             pend_q, pend_d;
    logic             tv_q, tv_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] top_q, top_d;
    logic             busy_q, busy_d;
    logic             entering_q, entering_d;

    logic             accept_c, is_op_c;
    logic             push_c, pop_c, repl_c, clear_c;
    logic [WIDTH-1:0] wdata_c, res_c, tos_c, nos_c;
    logic             full_c, empty_c;
    logic [PW-1:0]    count;

    rpn_stack_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear_c),
        .push    (push_c),
        .pop     (pop_c),
        .replace (repl_c),
        .wdata   (wdata_c),
        .top_c   (tos_c),
        .next_c  (nos_c),
        .count   (count),
        .full_c  (full_c),
        .empty_c (empty_c)
    );

    assign accept_c = token_valid && !tv_q && !busy_q;
    assign is_op_c  = (token == TOK_ADD) || (token == TOK_SUB) || ((token == TOK_MUL) && MUL_EN);

    // a = next, b = top; results wrap to WIDTH bits.
    always_comb begin
        res_c = '0;
        case (op_q)
            TOK_ADD: res_c = nos_c + tos_c;
            TOK_SUB: res_c = nos_c - tos_c;
`ifdef RPN_STACK_MUL_EN
            TOK_MUL: res_c = WIDTH'(nos_c * tos_c);
`endif
            default: res_c = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        op_d    = op_q;
        pend_d  = pend_q;
        tv_d    = token_valid;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push_c  = 1'b0;
        pop_c   = 1'b0;
        repl_c  = 1'b0;
        clear_c = 1'b0;
        wdata_c = entry_q;

        case (state_q)
            ST_IDLE: begin
                // An op that pushed a typed entry gets one settle cycle before EXEC.
                if (pend_q) begin
                    pend_d  = 1'b0;
                    state_d = ST_EXEC;
                end else if (accept_c) begin
                    if (is_digit(token)) begin
                        entry_d = WIDTH'(token);
                        state_d = ST_ENTRY;
                    end else if (token == TOK_ENTER) begin
                        if (empty_c) begin
                            unf_d = 1'b1;
                        end else if (full_c) begin
                            ovf_d = 1'b1;
                        end else begin
                            push_c  = 1'b1;
                            wdata_c = tos_c;
                        end
                    end else if (is_op_c) begin
                        op_d    = token;
                        state_d = ST_EXEC;
                    end else if (token == TOK_DROP) begin
                        if (empty_c) begin
                            unf_d = 1'b1;
                        end else begin
                            pop_c = 1'b1;
                        end
                    end
                end
            end
            ST_ENTRY: begin
                if (accept_c) begin
                    if (is_digit(token)) begin
                        entry_d = entry_q * WIDTH'(10) + WIDTH'(token);
                    end else if ((token == TOK_ENTER) || is_op_c) begin
                        if (full_c) begin
                            ovf_d = 1'b1;
                        end else begin
                            push_c = 1'b1;
                            if (is_op_c) begin
                                op_d   = token;
                                pend_d = 1'b1;
                            end
                        end
                        state_d = ST_IDLE;
                    end else if (token == TOK_DROP) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_EXEC: begin
                if (count < PW'(2)) begin
                    unf_d = 1'b1;
                end else begin
                    pop_c   = 1'b1;
                    repl_c  = 1'b1;
                    wdata_c = res_c;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept_c && (token == TOK_CLEAR)) begin
            clear_c = 1'b1;
            push_c  = 1'b0;
            pop_c   = 1'b0;
            repl_c  = 1'b0;
            entry_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
            pend_d  = 1'b0;
            state_d = ST_IDLE;
        end

        busy_d     = (state_d == ST_EXEC);
        entering_d = (state_d == ST_ENTRY);
        top_d      = (state_q == ST_ENTRY) ? entry_q : (empty_c ? '0 : tos_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            entry_q    <= '0;
            op_q       <= TOK_ADD;
            pend_q     <= 1'b0;
            tv_q       <= 1'b1;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            top_q      <= '0;
            busy_q     <= 1'b0;
            entering_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            entry_q    <= entry_d;
            op_q       <= op_d;
            pend_q     <= pend_d;
            tv_q       <= tv_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            top_q      <= top_d;
            busy_q     <= busy_d;
            entering_q <= entering_d;
        end
    end

    assign top           = top_q;
    assign depth         = count;
    assign entering      = entering_q;
    assign busy          = busy_q;
    assign err_overflow  = ovf_q;
    assign err_underflow = unf_q;

endmodule

// File: tb/tb_rpn_stack_engine.sv
// Self-checking bench for rpn_stack_engine against a queue-based calculator model.
module tb_rpn_stack_engine;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned MASK  = (32'd1 << WIDTH) - 1;
`ifdef RPN_STACK_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic [3:0]             token;
    logic                   token_valid;
    logic [WIDTH-1:0]       top;
    logic [$clog2(DEPTH):0] depth;
    logic                   entering, busy, err_overflow, err_underflow;

    int n_cmp = 0;
    int n_bad = 0;

    int unsigned stk[$];
    int unsigned ent;
    bit          typing, m_ovf, m_unf;

    rpn_stack_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .token         (token),
        .token_valid   (token_valid),
        .top           (top),
        .depth         (depth),
        .entering      (entering),
        .busy          (busy),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        stk.delete();
        ent    = 0;
        typing = 0;
        m_ovf  = 0;
        m_unf  = 0;
    endtask

    task automatic model_op(input logic [3:0] tok);
        int unsigned a, b, r;
        if (stk.size() < 2) begin
            m_unf = 1;
        end else begin
            b = stk.pop_back();
            a = stk.pop_back();
            case (tok)
                4'hA:    r = a + b;
                4'hB:    r = a - b;
                default: r = a * b;
            endcase
            stk.push_back(r & MASK);
        end
    endtask

    task automatic model_press(input logic [3:0] tok);
        bit is_op;
        is_op = (tok == 4'hA) || (tok == 4'hB) || ((tok == 4'hC) && MUL_EN);
        if (tok == 4'hF) begin
            model_clear();
        end else if (tok <= 4'd9) begin
            ent    = typing ? ((ent * 10 + tok) & MASK) : tok;
            typing = 1;
        end else if (typing) begin
            if (tok == 4'hE || is_op) begin
                typing = 0;
                if (stk.size() == DEPTH) m_ovf = 1;
                else begin
                    stk.push_back(ent);
                    if (is_op) model_op(tok);
                end
            end else if (tok == 4'hD) begin
                typing = 0;
            end
        end else begin
            if (tok == 4'hE) begin
                if (stk.size() == 0) m_unf = 1;
                else if (stk.size() == DEPTH) m_ovf = 1;
                else stk.push_back(stk[$]);
            end else if (tok == 4'hD) begin
                if (stk.size() == 0) m_unf = 1;
                else void'(stk.pop_back());
            end else if (is_op) begin
                model_op(tok);
            end
        end
    endtask

    function automatic int unsigned exp_top();
        if (typing) return ent;
        if (stk.size() > 0) return stk[$];
        return 0;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".top"}, 32'(top), exp_top());
        chk({tag, ".depth"}, 32'(depth), stk.size());
        chk({tag, ".entering"}, 32'(entering), 32'(typing));
        chk({tag, ".ovf"}, 32'(err_overflow), 32'(m_ovf));
        chk({tag, ".unf"}, 32'(err_underflow), 32'(m_unf));
        chk({tag, ".busy"}, 32'(busy), 0);
    endtask

    task automatic press(input logic [3:0] tok, input int hold);
        @(negedge clk);
        token       = tok;
        token_valid = 1'b1;
        repeat (hold) @(negedge clk);
        token_valid = 1'b0;
        repeat (5) @(negedge clk);
        model_press(tok);
    endtask

    task automatic press_num(input int unsigned v);
        if (v >= 10) press_num(v / 10);
        press(4'(v % 10), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    initial begin
        rst         = 1'b1;
        token       = 4'h0;
        token_valid = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all("reset");

        // 1,2,E
        press(4'h1, 1); press(4'h2, 1);
        check_all("typing12");
        press(4'hE, 1);
        check_all("enter12");

        // 12 E 7 A, cycle by cycle from ENTRY
        press(4'h7, 1);
        @(negedge clk); token = 4'hA; token_valid = 1'b1;
        @(negedge clk); token_valid = 1'b0;
        chk("lat_e.c1.busy", 32'(busy), 0);
        chk("lat_e.c1.depth", 32'(depth), 2);
        @(negedge clk);
        chk("lat_e.c2.busy", 32'(busy), 1);
        @(negedge clk);
        chk("lat_e.c3.busy", 32'(busy), 0);
        chk("lat_e.c3.top", 32'(top), 7);
        @(negedge clk);
        chk("lat_e.c4.top", 32'(top), 19);
        model_press(4'hA);
        check_all("add19");

        // op from IDLE: 19 - 5 with two-cycle latency
        press(4'h5, 1); press(4'hE, 1);
        @(negedge clk); token = 4'hB; token_valid = 1'b1;
        @(negedge clk); token_valid = 1'b0;
        chk("lat_i.c1.busy", 32'(busy), 1);
        @(negedge clk);
        chk("lat_i.c2.busy", 32'(busy), 0);
        chk("lat_i.c2.top", 32'(top), 5);
        @(negedge clk);
        chk("lat_i.c3.top", 32'(top), 14);
        model_press(4'hB);
        check_all("sub14");

        // 3 E 5 B wraps negative
        press(4'hF, 1);
        press(4'h3, 1); press(4'hE, 1); press(4'h5, 1); press(4'hB, 1);
        check_all("sub_wrap");
        chk("sub_wrap.const", 32'(top), 32'hFFFE);

        // edge arriving during EXEC is dropped
        press(4'h4, 1);
        @(negedge clk); token = 4'hA; token_valid = 1'b1;
        @(negedge clk); token_valid = 1'b0;
        @(negedge clk); token = 4'hD; token_valid = 1'b1;
        chk("drop_busy.busy", 32'(busy), 1);
        @(negedge clk); token_valid = 1'b0;
        repeat (4) @(negedge clk);
        model_press(4'hA);
        check_all("drop_busy");

        // fill the stack then overflow
        press(4'hF, 1);
        for (int i = 0; i < DEPTH; i++) begin
            press(4'(i + 1), 1); press(4'hE, 1);
        end
        press(4'h9, 1); press(4'hE, 1);
        check_all("overflow");
        chk("overflow.flag", 32'(err_overflow), 1);
        press(4'hE, 1);
        check_all("overflow_dup");
        press(4'hF, 1);
        check_all("clear");

        // underflow from reset, long hold accepts once
        do_reset();
        press(4'hA, 1000);
        check_all("underflow");
        chk("underflow.flag", 32'(err_underflow), 1);
        press(4'hF, 1);
        press(4'h1, 1); press(4'hE, 1); press(4'hE, 1);
        press(4'hE, 1000);
        check_all("hold_dup");
        chk("hold_dup.depth", 32'(depth), 3);

        // 300 E 300 C
        press(4'hF, 1);
        press_num(300); press(4'hE, 1); press_num(300); press(4'hC, 1);
        check_all("mul");

        // token_valid already high at reset release is ignored
        @(negedge clk);
        rst = 1'b1; token = 4'h5; token_valid = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        check_all("rst_held_tv");
        token_valid = 1'b0;

        // reset in the middle of EXEC clears everything
        press(4'hD, 1);
        press(4'h1, 1); press(4'hE, 1); press(4'h2, 1); press(4'hE, 1);
        @(negedge clk); token = 4'hA; token_valid = 1'b1;
        @(negedge clk); token_valid = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        model_clear();
        check_all("rst_exec");

        // random token stream
        for (int i = 0; i < 300; i++) begin
            int unsigned r;
            logic [3:0]  t;
            int          h;
            r = $urandom_range(0, 99);
            if (r < 45)      t = 4'($urandom_range(0, 9));
            else if (r < 55) t = 4'hA;
            else if (r < 63) t = 4'hB;
            else if (r < 71) t = 4'hC;
            else if (r < 79) t = 4'hD;
            else if (r < 97) t = 4'hE;
            else             t = 4'hF;
            h = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, 20)) : 1;
            press(t, h);
            check_all($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
